// File: rtl/regbank_pkg.sv
// Shared types and helpers for one-hot selected bus responders.
// Holds the select classification enum plus the one-hot decode,
// multi-hot detect and even-parity helper functions.
package regbank_pkg;

  localparam int MAX_SEL_W = 32;
  localparam int MAX_IDX_W = 5;
  localparam int MAX_DAT_W = 64;

  typedef enum logic [1:0] {
    SEL_IDLE  = 2'd0,
    SEL_VALID = 2'd1,
    SEL_BAD   = 2'd2
  } sel_class_e;

  // OR of the indices of all set bits; exact for a one-hot input.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_index(input logic [MAX_SEL_W-1:0] sel);
    logic [MAX_IDX_W-1:0] idx;
    idx = {MAX_IDX_W{1'b0}};
    for (int i = 0; i < MAX_SEL_W; i++) begin
      idx = sel[i] ? (idx | MAX_IDX_W'(i)) : idx;
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic popcount_gt1(input logic [MAX_SEL_W-1:0] v);
    return ((v & (v - 32'd1)) != 32'd0);
  endfunction

  // Even-parity bit: makes the total count of ones (data + bit) even.
  function automatic logic parity_even(input logic [MAX_DAT_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/register_bank_if.sv
// Executor-to-register-bank control and debug signals.
// The bidirectional data bus is a plain inout port on the bank so the
// tristate resolution stays on an ordinary net.
interface register_bank_if #(
  parameter int N  = 8,
  parameter int M  = 3,
  parameter int CW = 8,
  parameter int IW = (M > 1) ? $clog2(M) : 1
);
  logic [M-1:0]  MemorySelect;
  logic          MemoryRW;
  logic          ErrorClear;
  logic          Error;
  logic [CW-1:0] WriteCount;
  logic [IW-1:0] DebugIndex;
  logic [N-1:0]  DebugData;

  modport master (
    output MemorySelect, MemoryRW, ErrorClear, DebugIndex,
    input  Error, WriteCount, DebugData
  );

  modport slave (
    input  MemorySelect, MemoryRW, ErrorClear, DebugIndex,
    output Error, WriteCount, DebugData
  );
endinterface

// File: rtl/onehot_select_check.sv
// Classifies a one-hot select bus as idle / valid / bad and produces the
// binary index of the selected line. Usable by any one-hot bus responder.
module onehot_select_check
  import regbank_pkg::*;
#(
  parameter int M  = 3,
  parameter int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic [M-1:0]  i_sel,
  output sel_class_e    o_class,
  output logic [IW-1:0] o_index
);

  logic [MAX_SEL_W-1:0] w_sel_ext;

  assign w_sel_ext = MAX_SEL_W'(i_sel);
  assign o_index   = IW'(onehot_to_index(w_sel_ext));

  // Classify the select pattern by how many lines are asserted.
  always_comb begin
    o_class = SEL_IDLE;
    if (w_sel_ext == {MAX_SEL_W{1'b0}}) begin
      o_class = SEL_IDLE;
    end else if (popcount_gt1(w_sel_ext)) begin
      o_class = SEL_BAD;
    end else begin
      o_class = SEL_VALID;
    end
  end

endmodule

// File: rtl/register_bank.sv
// Register file responding on the executor's one-hot selected memory bus.
// Writes are captured on the rising clock edge, reads drive the shared bus
// combinationally, multi-hot selects raise a sticky Error, accepted writes
// are counted, and a side debug port exposes any cell.
// Optional feature macro: REGBANK_PARITY_EN (per-cell even parity, checked
// on reads, with a ParityInject port for corrupting the stored bit).
module register_bank
  import regbank_pkg::*;
#(
  parameter int N  = 8,
  parameter int M  = 3,
  parameter int CW = 8,
  localparam int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic           Clock,
  input  logic           ResetN,
  register_bank_if.slave bus,
  inout  wire  [N-1:0]   MemoryData
`ifdef REGBANK_PARITY_EN
  ,
  input  logic           ParityInject
`endif
);

  sel_class_e    w_class;
  logic [IW-1:0] w_idx;
  logic          w_valid;
  logic          w_bad;
  logic          w_wr;
  logic          w_rd;
  logic          w_drive;
  logic [N-1:0]  w_rd_data;
  logic          w_par_err;
  logic          w_set_err;

  logic [N-1:0]  r_cells [M];
  logic          r_error;
  logic [CW-1:0] r_wcount;

  onehot_select_check #(
    .M  (M),
    .IW (IW)
  ) u_sel_check (
    .i_sel   (bus.MemorySelect),
    .o_class (w_class),
    .o_index (w_idx)
  );

  assign w_valid   = (w_class == SEL_VALID);
  assign w_bad     = (w_class == SEL_BAD);
  assign w_wr      = w_valid & bus.MemoryRW;
  assign w_rd      = w_valid & ~bus.MemoryRW;
  assign w_rd_data = r_cells[w_idx];

  // The bank only owns the bus on a clean read outside reset.
  assign w_drive    = ResetN & w_rd;
  assign MemoryData = w_drive ? w_rd_data : {N{1'bz}};

`ifdef REGBANK_PARITY_EN
  logic r_par [M];

  assign w_par_err = w_rd & (parity_even(MAX_DAT_W'(w_rd_data)) != r_par[w_idx]);

  // Parity bit captured alongside each write; ParityInject corrupts it.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < M; i++) begin
        r_par[i] <= 1'b0;
      end
    end else if (w_wr) begin
      r_par[w_idx] <= parity_even(MAX_DAT_W'(MemoryData)) ^ ParityInject;
    end else begin
      r_par[w_idx] <= r_par[w_idx];
    end
  end
`else
  assign w_par_err = 1'b0;
`endif

  assign w_set_err = w_bad | w_par_err;

  // Cell storage: a valid write stores the bus value as-is, X/Z included.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < M; i++) begin
        r_cells[i] <= {N{1'b0}};
      end
    end else if (w_wr) begin
      r_cells[w_idx] <= MemoryData;
    end else begin
      r_cells[w_idx] <= r_cells[w_idx];
    end
  end

  // Accepted-write counter, wrapping silently.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_wcount <= {CW{1'b0}};
    end else if (w_wr) begin
      r_wcount <= r_wcount + CW'(1);
    end else begin
      r_wcount <= r_wcount;
    end
  end

  // Sticky error: a new fault in the same cycle beats ErrorClear.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_error <= 1'b0;
    end else if (w_set_err) begin
      r_error <= 1'b1;
    end else if (bus.ErrorClear) begin
      r_error <= 1'b0;
    end else begin
      r_error <= r_error;
    end
  end

  assign bus.Error      = r_error;
  assign bus.WriteCount = r_wcount;
  assign bus.DebugData  = (32'(bus.DebugIndex) < M) ? r_cells[bus.DebugIndex] : {N{1'b0}};

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Responder end of the executor's memory interface.
- Holds CELLS general registers of N bits each.
- Decodes the one-hot MemorySelect bus, captures writes on posedge Clock, and drives MemoryData during reads.
- Sits beside the executor as its register file. Adds sticky protocol-error detection, a write counter and a side debug read port for benches and display logic.

Parameters:
- N, 8, width of each register cell (bits); matches executor data bus.
- M, 3, MemorySelect width; one-hot, so cell count CELLS = M.
- CW, 8, width of the write counter (bits).

Ports:
- Clock  input  1  posedge clock, shared with executor.
- ResetN  input  1  asynchronous active-low reset.
- MemorySelect  input  M  one-hot cell select; all-zero = idle.
- MemoryData  inout  N  bidirectional data bus.
- MemoryRW  input  1  0 = read (bank drives bus), 1 = write (executor drives bus).
- ErrorClear  input  1  synchronous clear of sticky Error.
- Error  output  1  sticky protocol-error flag.
- WriteCount  output  CW  number of accepted writes, wraps.
- DebugIndex  input  $clog2(M)  binary index for debug read; min width 1.
- DebugData  output  N  combinational contents of cell DebugIndex.

Behaviour:
- Reset (ResetN low, async): all cells = 0, Error = 0, WriteCount = 0. MemoryData released (high-Z) while reset is asserted. Reset mid-write: the write is lost and the cell reads 0.
- Select classification, combinational on MemorySelect:
  - IDLE: all zero.
  - VALID: exactly one bit set.
  - BAD: two or more bits set.
- Write:
  - Condition: MemoryRW = 1 and VALID at posedge Clock.
  - Selected cell <= MemoryData. WriteCount <= WriteCount + 1, modulo 2^CW; wraps to 0 with no flag.
  - Latency: the new value is visible on DebugData and on reads starting the cycle after the edge.
- Read:
  - Condition: MemoryRW = 0 and VALID.
  - MemoryData driven combinationally with the selected cell; zero-cycle latency, so the value is sampleable at the same posedge.
  - No state change.
- Bus drive rule: MemoryData is high-Z whenever MemoryRW = 1, IDLE, BAD, or ResetN = 0. The bank never drives the bus while the executor does.
- BAD at a posedge (either RW):
  - No cell is written and WriteCount is unchanged.
  - Error <= 1.
  - Bus stays high-Z.
- Write with MemoryData containing X/Z: stored as-is. No checking.
- Error:
  - ErrorClear = 1 at a posedge with no BAD in the same cycle: Error <= 0.
  - BAD and ErrorClear in the same cycle: set wins, Error = 1.
- IDLE cycles: no state change.
- DebugData is combinational from storage. DebugIndex >= M returns 0.
- State elements:
  - storage array CELLS x N
  - Error flop
  - WriteCount register
  - parity array, only with the optional feature

Optional Feature:
- Macro: REGBANK_PARITY_EN.
- With macro defined:
  - Each cell stores an extra even-parity bit, computed from MemoryData on write; cleared to 0 on reset.
  - A VALID read whose recomputed parity mismatches the stored bit sets Error at that posedge.
  - Port ParityInject (input, 1) flips the stored parity bit on the write in the same cycle, for test.
- Without macro: no parity storage, no ParityInject port, and Error is set only by BAD select.

Decomposition:
- Shared package regbank_pkg holds:
  - the select classification enum (SEL_IDLE, SEL_VALID, SEL_BAD);
  - function onehot_to_index (M-bit one-hot to binary index);
  - function popcount_gt1.
- One natural sub-module: onehot_select_check, taking MemorySelect and producing class plus binary index. Reusable by other bus responders.
- Storage, counter and error logic stay in register_bank.

Test Plan:
- Reset then debug reads of every index -> DebugData = 0, Error = 0, WriteCount = 0, MemoryData high-Z.
- Write 8'hA5 with select 3'b010, RW = 1; next cycle read with select 3'b010, RW = 0 -> MemoryData = 8'hA5 same cycle, WriteCount = 1.
- Select 3'b011 with RW = 1 and data 8'hFF -> no cell changes, WriteCount unchanged, Error = 1. Pulse ErrorClear -> Error = 0. BAD plus ErrorClear in the same cycle -> Error stays 1.
- 256 consecutive valid writes from WriteCount = 0 with CW = 8 -> WriteCount = 0 (wrap) and the last value is stored.
- Assert ResetN low mid-sequence after writing 8'h3C to cell 0 -> cell 0 reads 0 immediately and WriteCount = 0, independent of Clock.
- REGBANK_PARITY_EN: write 8'h01 with ParityInject = 1, then read the same cell -> Error = 1 at the read edge. Write 8'h01 with ParityInject = 0 and read -> Error stays 0.
